sample_buffer_loader: RTL and testbench

Upstream feeder for the max/min difference HLSM. Accepts a stream of 8-bit samples over a valid/ready handshake and writes them into an internal DEPTH-entry register file. When the buffer is full, it issues a one-cycle `go` pulse to the HLSM and freezes its contents. The HLSM reads the samples through an asynchronous read port, and the loader re-arms when the HLSM reports `done`.

---
 rtl/sample_buffer_loader_if.sv | 25 ++
 rtl/sample_buffer_loader.sv | 106 ++++++++++
 tb/tb_sample_buffer_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sample_buffer_loader_if.sv
// Sample stream, HLSM read port and go/done handshake between the loader and its peers.
interface sample_buffer_loader_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          go;
  logic          consumer_done;

  // Peer side: upstream feeder plus the HLSM.
  modport master (
    output in_valid, in_data, rd_addr, consumer_done,
    input  in_ready, rd_data, go
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data, rd_addr, consumer_done,
    output in_ready, rd_data, go
  );
endinterface

// File: rtl/sample_buffer_loader.sv
// Collects DEPTH samples into a register file, pulses go to the HLSM when the
// frame is complete, holds the frame frozen and re-arms on a fresh done edge.
module sample_buffer_loader #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sample_buffer_loader_if.slave bus,
  input  logic                  flush_i,
  output logic [AW:0]           count_o,
  output logic                  full_o
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [AW:0] LAST_COUNT = (AW+1)'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          done_q;
  logic          wr_en;
  logic [DW-1:0] mem_q [DEPTH];

  // Next-state logic: fill while accepting, one go cycle, then wait for a new done edge.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    case (state_q)
      S_FILL: begin
        if (bus.in_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count_q + (AW+1)'(1);
          if (count_q == LAST_COUNT) begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.consumer_done && !done_q) begin
          count_d  = '0;
          wr_ptr_d = '0;
          state_d  = S_FILL;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
    // Flush overrides everything, including a coincident write.
    if (flush_i) begin
      state_d  = S_FILL;
      count_d  = '0;
      wr_ptr_d = '0;
      wr_en    = 1'b0;
    end
  end

  // Control registers; done_q tracks consumer_done every cycle for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FILL;
      wr_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      done_q   <= bus.consumer_done;
    end
  end

  // Sample storage, cleared only by reset and written only while filling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // Moore outputs decoded from state alone, so in_ready has no path from in_valid.
  always_comb begin
    bus.in_ready = (state_q == S_FILL);
    bus.go       = (state_q == S_START);
    full_o       = (state_q == S_START) || (state_q == S_WAIT);
    count_o      = count_q;
    bus.rd_data  = mem_q[bus.rd_addr];
  end

endmodule

// File: tb/tb_sample_buffer_loader.sv
// Self-checking bench for sample_buffer_loader: a per-cycle vector table for the
// first frame, a scoreboard of written samples, and hand sequences for the corners.
module tb_sample_buffer_loader;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int NVEC  = 21;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic [AW:0]  count;
  logic         full;

  sample_buffer_loader_if #(.DW(DW), .AW(AW)) bus ();

  sample_buffer_loader #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .flush_i (flush),
    .count_o (count),
    .full_o  (full)
  );

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    logic          flushIn;
    logic          done;
    logic          expReady;
    logic          expGo;
    logic [AW:0]   expCount;
    logic          expFull;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sbEntry_t;

  vec_t     vecs [NVEC];
  sbEntry_t sb [$];
  int       passCount;
  int       totalCount;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [DW-1:0] data,
                               input logic fl, input logic done);
    @(negedge clk);
    bus.in_valid      = valid;
    bus.in_data       = data;
    flush             = fl;
    bus.consumer_done = done;
    #1;
  endtask

  task automatic checkState(input string name, input logic ready, input logic go,
                            input logic [AW:0] cnt, input logic fu);
    checkOutput({name, ".in_ready"}, 32'(bus.in_ready), 32'(ready));
    checkOutput({name, ".go"},       32'(bus.go),       32'(go));
    checkOutput({name, ".count"},    32'(count),        32'(cnt));
    checkOutput({name, ".full"},     32'(full),         32'(fu));
  endtask

  task automatic drainScoreboard(input string name);
    sbEntry_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.rd_addr = e.addr;
      #1;
      checkOutput({name, ".rd_data"}, 32'(bus.rd_data), 32'(e.data));
    end
    bus.rd_addr = '0;
  endtask

  task automatic sendFrame(input string name, input int base);
    sbEntry_t e;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, DW'(base + i), 1'b0, 1'b0);
      checkState(name, 1'b1, 1'b0, (AW+1)'(i), 1'b0);
      e.addr = AW'(i);
      e.data = DW'(base + i);
      sb.push_back(e);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkState({name, ".start"}, 1'b0, 1'b1, (AW+1)'(DEPTH), 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkState({name, ".wait"}, 1'b0, 1'b0, (AW+1)'(DEPTH), 1'b1);
  endtask

  task automatic rearm(input string name);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput({name, ".still_wait"}, 32'(bus.in_ready), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkState({name, ".armed"}, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic checkMemCleared(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr = AW'(a);
      #1;
      checkOutput({name, ".rd_data"}, 32'(bus.rd_data), 32'd0);
    end
    bus.rd_addr = '0;
  endtask

  initial begin
    sbEntry_t e;
    passCount         = 0;
    totalCount        = 0;
    rst_n             = 1'b1;
    flush             = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.rd_addr       = '0;
    bus.consumer_done = 1'b0;

    // Frame 1 table: 16 transfers, START with backpressure, then WAIT under
    // in_valid=1/0xFF while consumer_done is already high on entry.
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].valid   = 1'b1;
      vecs[i].flushIn = 1'b0;
      vecs[i].done    = (i >= 14);
      if (i < DEPTH) begin
        vecs[i].data     = DW'(8'h10 + i);
        vecs[i].expReady = 1'b1;
        vecs[i].expGo    = 1'b0;
        vecs[i].expCount = (AW+1)'(i);
        vecs[i].expFull  = 1'b0;
      end else begin
        vecs[i].data     = 8'hFF;
        vecs[i].expReady = 1'b0;
        vecs[i].expGo    = (i == DEPTH);
        vecs[i].expCount = (AW+1)'(DEPTH);
        vecs[i].expFull  = 1'b1;
      end
    end

    // Asynchronous reset asserted mid-cycle.
    #7;
    rst_n = 1'b0;
    #1;
    checkState("reset", 1'b1, 1'b0, '0, 1'b0);
    checkMemCleared("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].flushIn, vecs[i].done);
      checkState($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expGo,
                 vecs[i].expCount, vecs[i].expFull);
      if (i < DEPTH) begin
        e.addr = AW'(i);
        e.data = vecs[i].data;
        sb.push_back(e);
      end
    end
    drainScoreboard("frame1");
    bus.rd_addr = AW'(5);
    #1;
    checkOutput("frame1.addr5", 32'(bus.rd_data), 32'h15);
    bus.rd_addr = '0;

    // Drop the held done level, then a fresh rising edge re-arms.
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkState("done_low", 1'b0, 1'b0, (AW+1)'(DEPTH), 1'b1);
    rearm("rearm1");

    sendFrame("frame2", 8'h20);
    drainScoreboard("frame2");
    rearm("rearm2");

    // Flush coincident with the 6th sample: the sample is dropped.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
      checkOutput("flushfill.count", 32'(count), 32'(i));
    end
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    checkOutput("flush.count_before", 32'(count), 32'd5);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkState("flush.after", 1'b1, 1'b0, '0, 1'b0);
    bus.rd_addr = AW'(5);
    #1;
    checkOutput("flush.addr5_kept", 32'(bus.rd_data), 32'h25);
    bus.rd_addr = AW'(4);
    #1;
    checkOutput("flush.addr4_written", 32'(bus.rd_data), 32'h44);
    bus.rd_addr = '0;

    sendFrame("frame3", 8'h60);
    drainScoreboard("frame3");

    // Reset while the frame is locked.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkState("rstwait", 1'b1, 1'b0, '0, 1'b0);
    checkMemCleared("rstwait");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkState("postrst.idle", 1'b1, 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkState("postrst.partial", 1'b1, 1'b0, (AW+1)'(3), 1'b0);

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
